// File: rtl/assoc_cache_pkg.sv
// cache_pkg: shared types, line geometry and address-field helpers for assoc_cache.
package cache_pkg;
  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_LINE = 4;
  function automatic logic [1:0] addr_off(input logic [29:0] a);
    return a[1:0];
  endfunction
  function automatic logic [27:0] addr_line(input logic [29:0] a);
    return a[29:2];
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/assoc_cache_lru.sv
// cache_lru: age update for a touched way and victim choice for one set.
module cache_lru #(
  parameter int WAYS = 2,
  parameter int AW = 1
) (
  input  logic [WAYS*AW-1:0] age_i,
  input  logic [WAYS-1:0]    valid_i,
  input  logic [AW-1:0]      way_i,
  output logic [WAYS*AW-1:0] age_o,
  output logic [AW-1:0]      victim_o
);
  logic [AW-1:0] hit_age;
  logic [AW-1:0] max_age;
  logic          found;
  always_comb begin
    hit_age = age_i[way_i*AW +: AW];
    age_o = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == way_i) age_o[w*AW +: AW] = '0;
      else if (age_i[w*AW +: AW] < hit_age) age_o[w*AW +: AW] = age_i[w*AW +: AW] + 1'b1;
    end
  end
  // invalid ways are filled first, lowest index wins; otherwise oldest way
  always_comb begin
    victim_o = '0;
    max_age = '0;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = AW'(w);
        found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && age_i[w*AW +: AW] >= max_age) begin
        max_age = age_i[w*AW +: AW];
        victim_o = AW'(w);
      end
    end
  end
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back/write-allocate cache, 128-bit line port.
// Optional hit/miss/write-back counters are built when ASSOC_CACHE_STATS_EN is defined.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 28 - IDX_W,
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [29:0]       proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [27:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
`ifdef ASSOC_CACHE_STATS_EN
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_miss,
  output logic [31:0]       stat_wb,
`endif
  input  logic              mem_ready
);
  state_e              state_q;
  logic [AW-1:0]       victim_q;
  logic [AW-1:0]       victim;
  logic [AW-1:0]       hit_way;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [TAG_W-1:0]    tag_q [WAYS][SETS];
  logic [LINE_W-1:0]   line_q [WAYS][SETS];
  logic [WAYS*AW-1:0]  age_q [SETS];
  logic [WAYS*AW-1:0]  age_d;
  logic [27:0]         line_a;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          off;
  logic                req;
  logic                hit;
  logic                touch;
  logic                wr_hit;
  logic                fill;

  assign line_a = addr_line(proc_addr);
  assign idx = line_a[IDX_W-1:0];
  assign tag = line_a[27:IDX_W];
  assign off = addr_off(proc_addr);
  assign req = proc_read | proc_write;

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  assign touch = (state_q == COMPARE) && req && hit;
  assign wr_hit = touch && proc_write;
  assign fill = (state_q == ALLOCATE) && mem_ready;
  assign proc_stall = req && !touch;
  assign proc_rdata = touch ? line_q[hit_way][idx][off*WORD_W +: WORD_W] : '0;

  cache_lru #(.WAYS(WAYS), .AW(AW)) u_lru (
    .age_i   (age_q[idx]),
    .valid_i (valid_q[idx]),
    .way_i   (hit_way),
    .age_o   (age_d),
    .victim_o(victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COMPARE;
      victim_q <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_q)
        COMPARE: if (req && !hit) begin
          victim_q <= victim;
          if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
            state_q <= WRITEBACK;
            mem_write <= 1'b1;
            mem_addr <= {tag_q[victim][idx], idx};
            mem_wdata <= line_q[victim][idx];
          end else begin
            state_q <= ALLOCATE;
            mem_read <= 1'b1;
            mem_addr <= line_a;
          end
        end
        WRITEBACK: if (mem_ready) begin
          state_q <= ALLOCATE;
          mem_write <= 1'b0;
          mem_read <= 1'b1;
          mem_addr <= line_a;
        end
        ALLOCATE: if (mem_ready) begin
          state_q <= COMPARE;
          mem_read <= 1'b0;
        end
        default: state_q <= COMPARE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w*AW +: AW] <= AW'(w);
      end
    end else begin
      if (touch) age_q[idx] <= age_d;
      if (wr_hit) dirty_q[idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      line_q[victim_q][idx] <= mem_rdata;
      tag_q[victim_q][idx] <= tag;
    end else if (wr_hit) begin
      line_q[hit_way][idx][off*WORD_W +: WORD_W] <= proc_wdata;
    end
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic retry_q;
  // the hit that follows a fill is the same access as the miss, so it is not a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 1'b0;
      stat_hit <= '0;
      stat_miss <= '0;
      stat_wb <= '0;
    end else begin
      retry_q <= fill ? 1'b1 : (touch ? 1'b0 : retry_q);
      if (touch && !retry_q) stat_hit <= sat_inc(stat_hit);
      if (state_q == COMPARE && req && !hit) stat_miss <= sat_inc(stat_miss);
      if (state_q == WRITEBACK && mem_ready) stat_wb <= sat_inc(stat_wb);
    end
  end
`else
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed accesses checked against an LRU-list cache model and a line memory.
module tb_assoc_cache;
  localparam int WAYS = 2;
  localparam int SETS = 4;
  localparam int K = 3;

  typedef struct packed {
    logic [27:0]  line;
    logic         dirty;
    logic [127:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0]  stat_hit, stat_miss, stat_wb;
`endif

  int passes = 0;
  int total = 0;
  int rd_done = 0;
  int wr_done = 0;
  logic [27:0] last_rd_addr = '0;
  logic [27:0] last_wr_addr = '0;
  logic [127:0] memarr [logic [27:0]];
  ent_t cq[$];

  always #5 clk = ~clk;

  assoc_cache #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ASSOC_CACHE_STATS_EN
    .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_wb(stat_wb),
`endif
    .mem_ready(mem_ready)
  );

  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic logic [127:0] get_line(input logic [27:0] l);
    logic [127:0] v;
    if (memarr.exists(l)) return memarr[l];
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = 32'({l, 2'(i)}) - 32'd15;
    return v;
  endfunction

  // memory: answers each request on its K-th cycle; also watches request hygiene
  initial begin
    int cnt;
    logic prev_busy, prev_ready;
    logic [27:0] prev_addr;
    cnt = 0;
    prev_busy = 1'b0;
    prev_ready = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("mem_excl", mem_read && mem_write, 1'b0);
        if ((mem_read || mem_write) && prev_busy && !prev_ready) check("mem_addr_hold", mem_addr, prev_addr);
      end
      prev_busy = rst_n && (mem_read || mem_write);
      prev_addr = mem_addr;
      mem_ready = 1'b0;
      if (rst_n && (mem_read || mem_write)) begin
        cnt++;
        if (cnt == K) begin
          cnt = 0;
          mem_ready = 1'b1;
          if (mem_write) begin
            memarr[mem_addr] = mem_wdata;
            wr_done++;
            last_wr_addr = mem_addr;
          end else begin
            mem_rdata = get_line(mem_addr);
            rd_done++;
            last_rd_addr = mem_addr;
          end
        end
      end else cnt = 0;
      prev_ready = mem_ready;
    end
  end

  task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    logic [27:0] l;
    int pos, cnt, ev, exp_st, rd0, wr0;
    bit wb, done;
    ent_t e, evd;
    l = a[29:2];
    pos = -1; cnt = 0; ev = -1; wb = 1'b0; done = 1'b0;
    rd0 = rd_done; wr0 = wr_done;
    evd = '0;
    for (int i = 0; i < cq.size(); i++) begin
      if (cq[i].line == l) pos = i;
      if (cq[i].line[1:0] == l[1:0]) begin
        cnt++;
        ev = i;
      end
    end
    if (pos >= 0) begin
      e = cq[pos];
      cq.delete(pos);
      exp_st = 0;
    end else begin
      if (cnt == WAYS) begin
        evd = cq[ev];
        cq.delete(ev);
        wb = evd.dirty;
      end
      e.line = l;
      e.dirty = 1'b0;
      e.data = get_line(l);
      exp_st = wb ? 1 + 2 * K : 1 + K;
    end
    proc_addr = a;
    proc_wdata = d;
    proc_read = !wr;
    proc_write = wr;
    stalls = 0;
    rd = '0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (!proc_stall) begin
        done = 1'b1;
        rd = proc_rdata;
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      $display("FAIL timeout: access %0h still stalled, required service", a);
    end
    @(negedge clk);
    proc_read = 1'b0;
    proc_write = 1'b0;
    check("stall_cycles", stalls, exp_st);
    if (!wr) check("rdata", rd, e.data[a[1:0]*32 +: 32]);
    check("fills", rd_done - rd0, pos < 0);
    check("writebacks", wr_done - wr0, wb);
    if (wb) check("wb_data", get_line(evd.line), evd.data);
    if (wr) begin
      e.data[a[1:0]*32 +: 32] = d;
      e.dirty = 1'b1;
    end
    cq.push_front(e);
  endtask

  initial begin
    int st;
    logic [31:0] rd;
    logic [127:0] l4;
    bit seen;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", proc_stall, 1'b0);
    check("rst_rdata", proc_rdata, 32'h0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // cold read and rehit
    access(0, 30'h10, 0, st, rd);
    check("t1_stall", st, 4);
    check("t1_rdata", rd, 32'd1);
    check("t1_fill_addr", last_rd_addr, 28'h4);
    access(0, 30'h10, 0, st, rd);
    check("t1_rehit", st, 0);
    // write hit then neighbouring words
    access(1, 30'h10, 32'hDEADBEEF, st, rd);
    check("t2_whit", st, 0);
    for (int i = 1; i < 4; i++) begin
      access(0, 30'h10 + 30'(i), 0, st, rd);
      check("t2_word", rd, 32'(i + 1));
    end
    access(0, 30'h10, 0, st, rd);
    check("t2_written", rd, 32'hDEADBEEF);
    // LRU in set 1: A, B, touch A, C evicts B
    access(0, 30'h04, 0, st, rd);
    access(0, 30'h24, 0, st, rd);
    access(0, 30'h04, 0, st, rd);
    check("t3_touch_a", st, 0);
    access(0, 30'h44, 0, st, rd);
    check("t3_miss_c", st, 4);
    access(0, 30'h04, 0, st, rd);
    check("t3_a_kept", st, 0);
    access(0, 30'h24, 0, st, rd);
    check("t3_b_gone", st, 4);
    // dirty eviction in set 0
    access(0, 30'h20, 0, st, rd);
    access(0, 30'h30, 0, st, rd);
    check("t4_dirty_stall", st, 1 + 2 * K);
    check("t4_wb_addr", last_wr_addr, 28'h4);
    l4 = get_line(28'h4);
    check("t4_wb_word0", l4[31:0], 32'hDEADBEEF);
    access(0, 30'h10, 0, st, rd);
    check("t4_refetch", rd, 32'hDEADBEEF);
    // reset during a fill drops the request and the dirty line
    access(1, 30'h11, 32'h12345678, st, rd);
    proc_addr = 30'h50;
    proc_read = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = mem_read;
    end
    check("t5_read_issued", seen, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rd_drop", mem_read, 1'b0);
    check("t5_wr_low", mem_write, 1'b0);
    proc_read = 1'b0;
    cq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 30'h11, 0, st, rd);
    check("t5_remiss", st, 4);
    check("t5_lost_write", rd, 32'd2);
    access(0, 30'h10, 0, st, rd);
    check("t5_kept_wb", rd, 32'hDEADBEEF);
    // write miss allocates
    access(1, 30'h71, 32'hCAFEF00D, st, rd);
    check("t6_wmiss", st, 4);
    access(0, 30'h71, 0, st, rd);
    check("t6_wdata", rd, 32'hCAFEF00D);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
